// File: rtl/axi4_w_sender_if.sv
// rtl/axi4_w_sender_if.sv - AXI4 write-data channel bundle
// Purpose: groups one W channel (data, strobes, last, user, valid/ready).
// Ports (signals):
//   wdata/wstrb/wlast/wuser/wvalid : driven by the channel master
//   wready                         : driven by the channel slave
// Modports: master (drives W beats), slave (accepts W beats).
interface axi4_w_sender_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 4
);
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [USER_W-1:0]   wuser;
  logic                wvalid;
  logic                wready;

  modport master (output wdata, output wstrb, output wlast, output wuser,
                  output wvalid, input wready);
  modport slave  (input wdata, input wstrb, input wlast, input wuser,
                  input wvalid, output wready);
endinterface

// File: rtl/axi4_w_sender.sv
// rtl/axi4_w_sender.sv - W-burst release/discard stage driven by AW decisions
// Purpose: holds per-transaction forward/drop decisions in a small FIFO and
//   either passes the head W burst straight to the master port or swallows it.
// Ports:
//   axi4_aclk, axi4_arstn : clock, asynchronous active-low reset
//   cmd_valid, cmd_drop   : one AW decision per pulse (1 = discard burst)
//   cmd_full              : decision queue full (stalls the AW sender)
//   s_axi4                : slave-side W channel (beats in)
//   m_axi4                : master-side W channel (beats out)
//   drop_done             : last beat of a discarded burst consumed
//   overflow_err          : sticky, a decision arrived with no room for it
module axi4_w_sender #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 4,
  parameter int CMD_DEPTH      = 4
) (
  input  logic                    axi4_aclk,
  input  logic                    axi4_arstn,
  input  logic                    cmd_valid,
  input  logic                    cmd_drop,
  output logic                    cmd_full,
  axi4_w_sender_if.slave          s_axi4,
  axi4_w_sender_if.master         m_axi4,
  output logic                    drop_done,
  output logic                    overflow_err
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [CMD_DEPTH-1:0] r_q;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_full;
  logic                 r_ovf;
  logic [1:0]           r_state;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_ovf;
  logic                        w_s_wready;
  logic                        w_m_wvalid;
  logic                        w_drop_done;
  logic [PTR_W-1:0]            w_wptr_nxt;
  logic [PTR_W-1:0]            w_rptr_nxt;
  logic [CNT_W-1:0]            w_count_nxt;
  logic                        w_head_nxt;
  logic [1:0]                  w_state_nxt;
  logic [AXI_DATA_WIDTH-1:0]   w_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] w_wstrb;
  logic [AXI_USER_WIDTH-1:0]   w_wuser;

  // Payload is passed through unconditionally; only valid/ready are gated.
  assign w_wdata       = s_axi4.wdata;
  assign w_wstrb       = s_axi4.wstrb;
  assign w_wuser       = s_axi4.wuser;
  assign m_axi4.wdata  = w_wdata;
  assign m_axi4.wstrb  = w_wstrb;
  assign m_axi4.wuser  = w_wuser;
  assign m_axi4.wlast  = s_axi4.wlast;
  assign m_axi4.wvalid = w_m_wvalid;
  assign s_axi4.wready = w_s_wready;

  always_comb begin
    w_s_wready  = 1'b0;
    w_m_wvalid  = 1'b0;
    w_pop       = 1'b0;
    w_drop_done = 1'b0;
    case (r_state)
      ST_FWD: begin
        w_m_wvalid = s_axi4.wvalid;
        w_s_wready = m_axi4.wready;
        w_pop      = s_axi4.wvalid & m_axi4.wready & s_axi4.wlast;
      end
      ST_DROP: begin
        w_s_wready  = 1'b1;
        w_pop       = s_axi4.wvalid & s_axi4.wlast;
        w_drop_done = w_pop;
      end
      default: ;
    endcase
  end

  // A full queue still accepts a decision in the cycle its head retires.
  assign w_push = cmd_valid & (~r_full | w_pop);
  assign w_ovf  = cmd_valid & r_full & ~w_pop;

  assign w_wptr_nxt = w_push ? r_wptr + 1'b1 : r_wptr;
  assign w_rptr_nxt = w_pop  ? r_rptr + 1'b1 : r_rptr;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  // The next head is the entry being written this cycle when the queue is
  // empty after the pop (or was empty); otherwise it is already stored.
  assign w_head_nxt = (w_push && (r_wptr == w_rptr_nxt)) ? cmd_drop : r_q[w_rptr_nxt];

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_count_nxt != '0) w_state_nxt = w_head_nxt ? ST_DROP : ST_FWD;
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_q     <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      if (w_push) r_q[r_wptr] <= cmd_drop;
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(CMD_DEPTH));
      if (w_ovf) r_ovf <= 1'b1;
      r_state <= w_state_nxt;
    end
  end

  assign cmd_full     = r_full;
  assign drop_done    = w_drop_done;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_axi4_w_sender.sv
// tb/tb_axi4_w_sender.sv - directed self-checking bench for axi4_w_sender
module tb_axi4_w_sender;

  logic clk;
  logic rst_n;
  logic cmd_valid;
  logic cmd_drop;
  logic cmd_full;
  logic drop_done;
  logic overflow_err;

  int n_checks;
  int n_fail;

  axi4_w_sender_if #(.DATA_W(64), .USER_W(4)) s_if ();
  axi4_w_sender_if #(.DATA_W(64), .USER_W(4)) m_if ();

  axi4_w_sender #(
    .AXI_DATA_WIDTH(64),
    .AXI_USER_WIDTH(4),
    .CMD_DEPTH     (4)
  ) dut (
    .axi4_aclk   (clk),
    .axi4_arstn  (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_drop    (cmd_drop),
    .cmd_full    (cmd_full),
    .s_axi4      (s_if),
    .m_axi4      (m_if),
    .drop_done   (drop_done),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] s, input logic l, input logic [3:0] u);
    s_if.wvalid = 1'b1;
    s_if.wdata  = d;
    s_if.wstrb  = s;
    s_if.wlast  = l;
    s_if.wuser  = u;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_drop = 1'b0;
    s_if.wvalid = 1'b0;
    s_if.wdata = '0;
    s_if.wstrb = '0;
    s_if.wlast = 1'b0;
    s_if.wuser = '0;
    m_if.wready = 1'b1;
    #3;
    n_checks++; if (s_if.wready !== 1'b0) begin n_fail++; $display("FAIL reset_s_wready got %b want 0", s_if.wready); end
    n_checks++; if (m_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_wvalid got %b want 0", m_if.wvalid); end
    n_checks++; if (cmd_full !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_full got %b want 0", cmd_full); end
    n_checks++; if (drop_done !== 1'b0) begin n_fail++; $display("FAIL reset_drop_done got %b want 0", drop_done); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow_err); end
    n_checks++; if (dut.r_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", dut.r_count); end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_fwd_burst();
    cmd_valid = 1'b1;
    cmd_drop = 1'b0;
    m_if.wready = 1'b1;
    beat(64'hA5A5_0000_0000_0000, 8'h01, 1'b0, 4'd0);
    settle();
    n_checks++; if (m_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL fwd_idle_wvalid got %b want 0", m_if.wvalid); end
    n_checks++; if (s_if.wready !== 1'b0) begin n_fail++; $display("FAIL fwd_idle_wready got %b want 0", s_if.wready); end
    next_cycle();
    cmd_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      beat(64'hA5A5_0000_0000_0000 + 64'(b), 8'h01 << b, (b == 3), 4'(b));
      settle();
      n_checks++; if (m_if.wvalid !== 1'b1) begin n_fail++; $display("FAIL fwd_wvalid beat %0d got %b want 1", b, m_if.wvalid); end
      n_checks++; if (m_if.wdata !== 64'hA5A5_0000_0000_0000 + 64'(b)) begin n_fail++; $display("FAIL fwd_wdata beat %0d got %h", b, m_if.wdata); end
      n_checks++; if (m_if.wstrb !== (8'h01 << b)) begin n_fail++; $display("FAIL fwd_wstrb beat %0d got %h", b, m_if.wstrb); end
      n_checks++; if (s_if.wready !== 1'b1) begin n_fail++; $display("FAIL fwd_s_wready beat %0d got %b want 1", b, s_if.wready); end
      next_cycle();
    end
    s_if.wvalid = 1'b0;
    s_if.wlast = 1'b0;
    settle();
    n_checks++; if (dut.r_count !== 3'd0) begin n_fail++; $display("FAIL fwd_count_end got %0d want 0", dut.r_count); end
    n_checks++; if (s_if.wready !== 1'b0) begin n_fail++; $display("FAIL fwd_idle_end got %b want 0", s_if.wready); end
    next_cycle();
  endtask

  task automatic test_drop();
    cmd_valid = 1'b1;
    cmd_drop = 1'b1;
    next_cycle();
    cmd_valid = 1'b0;
    beat(64'h1111, 8'hFF, 1'b0, 4'd1);
    settle();
    n_checks++; if (s_if.wready !== 1'b1) begin n_fail++; $display("FAIL drop_wready got %b want 1", s_if.wready); end
    n_checks++; if (m_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL drop_m_wvalid0 got %b want 0", m_if.wvalid); end
    n_checks++; if (drop_done !== 1'b0) begin n_fail++; $display("FAIL drop_done_early got %b want 0", drop_done); end
    next_cycle();
    beat(64'h2222, 8'hFF, 1'b1, 4'd2);
    settle();
    n_checks++; if (drop_done !== 1'b1) begin n_fail++; $display("FAIL drop_done_last got %b want 1", drop_done); end
    n_checks++; if (m_if.wvalid !== 1'b0) begin n_fail++; $display("FAIL drop_m_wvalid1 got %b want 0", m_if.wvalid); end
    next_cycle();
    s_if.wvalid = 1'b0;
    s_if.wlast = 1'b0;
    settle();
    n_checks++; if (drop_done !== 1'b0) begin n_fail++; $display("FAIL drop_done_after got %b want 0", drop_done); end
    n_checks++; if (dut.r_count !== 3'd0) begin n_fail++; $display("FAIL drop_count got %0d want 0", dut.r_count); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1;
    cmd_drop = 1'b0;
    next_cycle();
    cmd_drop = 1'b1;
    next_cycle();
    cmd_drop = 1'b0;
    next_cycle();
    cmd_valid = 1'b0;
    beat(64'hB001, 8'h0F, 1'b1, 4'd3);
    settle();
    n_checks++; if (m_if.wvalid !== 1'b1 || m_if.wdata !== 64'hB001) begin n_fail++; $display("FAIL b2b_beat1 got v=%b d=%h want v=1 d=b001", m_if.wvalid, m_if.wdata); end
    next_cycle();
    beat(64'hB002, 8'h0F, 1'b1, 4'd3);
    settle();
    n_checks++; if (m_if.wvalid !== 1'b0 || s_if.wready !== 1'b1 || drop_done !== 1'b1) begin n_fail++; $display("FAIL b2b_beat2 got v=%b r=%b dd=%b want 0 1 1", m_if.wvalid, s_if.wready, drop_done); end
    next_cycle();
    beat(64'hB003, 8'h0F, 1'b1, 4'd3);
    settle();
    n_checks++; if (m_if.wvalid !== 1'b1 || m_if.wdata !== 64'hB003 || s_if.wready !== 1'b1) begin n_fail++; $display("FAIL b2b_beat3 got v=%b d=%h r=%b", m_if.wvalid, m_if.wdata, s_if.wready); end
    next_cycle();
    s_if.wvalid = 1'b0;
    s_if.wlast = 1'b0;
    settle();
    n_checks++; if (dut.r_count !== 3'd0) begin n_fail++; $display("FAIL b2b_count got %0d want 0", dut.r_count); end
    next_cycle();
  endtask

  task automatic test_stall();
    cmd_valid = 1'b1;
    cmd_drop = 1'b0;
    m_if.wready = 1'b1;
    beat(64'hC000, 8'h03, 1'b0, 4'd4);
    next_cycle();
    cmd_valid = 1'b0;
    next_cycle();
    beat(64'hC001, 8'h0C, 1'b0, 4'd5);
    m_if.wready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++; if (m_if.wvalid !== 1'b1 || m_if.wdata !== 64'hC001 || m_if.wstrb !== 8'h0C) begin n_fail++; $display("FAIL stall_hold cyc %0d got v=%b d=%h s=%h", c, m_if.wvalid, m_if.wdata, m_if.wstrb); end
      n_checks++; if (s_if.wready !== 1'b0) begin n_fail++; $display("FAIL stall_wready cyc %0d got %b want 0", c, s_if.wready); end
      n_checks++; if (dut.r_count !== 3'd1) begin n_fail++; $display("FAIL stall_count cyc %0d got %0d want 1", c, dut.r_count); end
      next_cycle();
    end
    m_if.wready = 1'b1;
    next_cycle();
    beat(64'hC002, 8'h30, 1'b1, 4'd6);
    next_cycle();
    s_if.wvalid = 1'b0;
    s_if.wlast = 1'b0;
    settle();
    n_checks++; if (dut.r_count !== 3'd0) begin n_fail++; $display("FAIL stall_count_end got %0d want 0", dut.r_count); end
    next_cycle();
  endtask

  task automatic test_overflow();
    s_if.wvalid = 1'b0;
    cmd_drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      next_cycle();
    end
    cmd_valid = 1'b0;
    settle();
    n_checks++; if (cmd_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", cmd_full); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow_err); end
    next_cycle();
    cmd_valid = 1'b1;
    m_if.wready = 1'b1;
    beat(64'hD000, 8'hFF, 1'b1, 4'd7);
    next_cycle();
    cmd_valid = 1'b0;
    s_if.wvalid = 1'b0;
    settle();
    n_checks++; if (dut.r_count !== 3'd4) begin n_fail++; $display("FAIL ovf_pushpop_count got %0d want 4", dut.r_count); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop_err got %b want 0", overflow_err); end
    next_cycle();
    cmd_valid = 1'b1;
    cmd_drop = 1'b1;
    next_cycle();
    cmd_valid = 1'b0;
    cmd_drop = 1'b0;
    settle();
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b want 1", overflow_err); end
    n_checks++; if (dut.r_count !== 3'd4 || cmd_full !== 1'b1) begin n_fail++; $display("FAIL ovf_count got %0d full=%b want 4 1", dut.r_count, cmd_full); end
    next_cycle();
    beat(64'hD001, 8'hFF, 1'b1, 4'd8);
    for (int i = 0; i < 4; i++) next_cycle();
    s_if.wvalid = 1'b0;
    s_if.wlast = 1'b0;
    settle();
    n_checks++; if (dut.r_count !== 3'd0 || cmd_full !== 1'b0) begin n_fail++; $display("FAIL ovf_drain got %0d full=%b want 0 0", dut.r_count, cmd_full); end
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    cmd_valid = 1'b1;
    cmd_drop = 1'b0;
    m_if.wready = 1'b1;
    beat(64'hE000, 8'hFF, 1'b0, 4'd9);
    next_cycle();
    cmd_valid = 1'b0;
    next_cycle();
    beat(64'hE001, 8'hFF, 1'b0, 4'd9);
    settle();
    n_checks++; if (m_if.wvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %b want 1", m_if.wvalid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_if.wvalid !== 1'b0 || s_if.wready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async got v=%b r=%b want 0 0", m_if.wvalid, s_if.wready); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf got %b want 0", overflow_err); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    settle();
    n_checks++; if (dut.r_count !== 3'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d want 0", dut.r_count); end
    n_checks++; if (m_if.wvalid !== 1'b0 || s_if.wready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_noresume got v=%b r=%b want 0 0", m_if.wvalid, s_if.wready); end
    s_if.wvalid = 1'b0;
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_fwd_burst();
    test_drop();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_w_sender.md
Name: axi4_w_sender

Overview:
- Write-data stage that runs alongside the AW sender in the RAB slave-to-master path.
- Consumes the per-transaction decisions produced upstream: forwarded by L1, forwarded by L2 after a miss, or dropped.
- Releases each W burst to the master port only after its AW has been forwarded; discards the beats of dropped transactions.
- Exports back-pressure so AW can be stalled when the decision queue is full.

Parameters:
AXI_DATA_WIDTH, 64, width of wdata; wstrb is AXI_DATA_WIDTH/8
AXI_USER_WIDTH, 4, width of wuser
CMD_DEPTH, 4, decision-queue entries; power of two, >=2

Ports:
axi4_aclk  in  1  clock
axi4_arstn  in  1  reset; asynchronous assert, active-low
cmd_valid  in  1  pulse: one AW decision, delivered in AW order
cmd_drop  in  1  qualifies cmd_valid: 1=discard burst, 0=forward burst
cmd_full  out  1  decision queue full; drives stall_aw of the AW sender
s_axi4_wdata  in  AXI_DATA_WIDTH  slave W data
s_axi4_wstrb  in  AXI_DATA_WIDTH/8  slave W strobes
s_axi4_wlast  in  1  slave W last beat
s_axi4_wuser  in  AXI_USER_WIDTH  slave W user
s_axi4_wvalid  in  1  slave W valid
s_axi4_wready  out  1  slave W ready
m_axi4_wdata  out  AXI_DATA_WIDTH  master W data
m_axi4_wstrb  out  AXI_DATA_WIDTH/8  master W strobes
m_axi4_wlast  out  1  master W last
m_axi4_wuser  out  AXI_USER_WIDTH  master W user
m_axi4_wvalid  out  1  master W valid
m_axi4_wready  in  1  master W ready
drop_done  out  1  pulse: last beat of a discarded burst consumed (feeds B-error generator)
overflow_err  out  1  sticky: cmd_valid while full and no pop that cycle

Behaviour:
- Reset values (async, immediate): queue empty, count=0, state IDLE.
- Outputs in reset: s_axi4_wready=0, m_axi4_wvalid=0, cmd_full=0, drop_done=0, overflow_err=0.
- Decision queue: CMD_DEPTH x 1-bit (drop flag) circular FIFO.
  - Write and read pointers are $clog2(CMD_DEPTH) bits and wrap modulo CMD_DEPTH.
  - count is $clog2(CMD_DEPTH)+1 bits.
- Push: cmd_valid & (~cmd_full | pop). Pop: last-beat handshake of the head burst (defined below).
- Simultaneous push and pop: count unchanged. This is legal when full; that push is accepted.
- cmd_full = (count==CMD_DEPTH), registered.
- Push while full with no pop: entry discarded, queue unchanged, overflow_err set to 1 and held until reset.
- State is registered and tracks the head entry:
  - IDLE when count==0.
  - FWD when head drop=0.
  - DROP when head drop=1.
- IDLE: s_axi4_wready=0, m_axi4_wvalid=0; incoming beats wait.
  - A push into the empty queue takes effect next cycle: IDLE->FWD/DROP, so first-beat latency after cmd_valid is 1 cycle.
- FWD: zero-latency pass-through.
  - m_axi4_w* = s_axi4_w*; m_axi4_wvalid = s_axi4_wvalid; s_axi4_wready = m_axi4_wready.
  - Pop on s_axi4_wvalid & m_axi4_wready & s_axi4_wlast.
- DROP: s_axi4_wready=1, m_axi4_wvalid=0; beats are consumed and discarded.
  - Pop and drop_done=1 (same cycle, combinational) on s_axi4_wvalid & s_axi4_wlast.
- On pop, the next state comes from the new head. Back-to-back bursts lose no cycle, e.g. FWD->DROP directly.
- Master-side data outputs are don't-care when m_axi4_wvalid=0. They are driven from the slave side and never X-gated.
- Once m_axi4_wvalid is asserted it must not drop before m_axi4_wready, because the state cannot change mid-beat. This relies on the slave obeying the AXI valid rule.
- Beats arriving before their decision stall; W-before-AW ordering is therefore supported.
- Reset mid-burst: queue and state clear immediately. No partial burst is resumed after reset.

Test Plan:
- Reset, then cmd_valid, cmd_drop=0 at cycle 0; 4-beat burst already valid, m_axi4_wready=1 -> m_axi4_wvalid from cycle 1, 4 beats passed on cycles 1-4 with identical data/strb, queue empty at cycle 5.
- cmd_drop=1 decision, 2-beat burst -> s_axi4_wready=1, m_axi4_wvalid stays 0, drop_done pulses once on the wlast beat.
- Decisions F,D,F pushed back-to-back, three 1-beat bursts streamed -> beats 1 and 3 appear on master, beat 2 discarded, no idle cycle between bursts.
- Master holds m_axi4_wready=0 for 3 cycles mid-burst -> m_axi4_wvalid and data stable, s_axi4_wready=0 throughout, no pop.
- CMD_DEPTH=4: 4 pushes with no W traffic -> cmd_full=1. 5th push alone -> overflow_err=1, count stays 4. Push coincident with a pop -> accepted, no error.
- Reset asserted during beat 2 of a 4-beat forwarded burst -> m_axi4_wvalid=0 and s_axi4_wready=0 immediately, count=0 after release.
